// File: rtl/pe_pkg.sv
// Shared defaults and arithmetic helpers for the convolution PE array.
package pe_pkg;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_FRAC_BITS  = 16;
  localparam int DEF_KNL_DIM    = 5;
  localparam int DEF_KNL_MAXNUM = 16;

  function automatic longint rnd_const(int frac);
    return longint'(1) << (frac - 1);
  endfunction

  localparam longint RND = rnd_const(DEF_FRAC_BITS);

  function automatic longint sat_max(int w);
    return (longint'(1) << (w - 1)) - 1;
  endfunction

  function automatic longint sat_min(int w);
    return -(longint'(1) << (w - 1));
  endfunction
endpackage

// File: rtl/pe_array_conv_if.sv
// Load/control/result bundle between a host and the PE array.
interface pe_array_conv_if import pe_pkg::*; #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int KNL_MAXNUM = DEF_KNL_MAXNUM
);
  localparam int NW = $clog2(KNL_MAXNUM) + 1;
  localparam int CW = $clog2(KNL_MAXNUM);

  logic [DATA_WIDTH-1:0] data_in;
  logic                  en_ld_knl;
  logic                  en_ld_ifmap;
  logic                  mac_start;
  logic [NW-1:0]         num_knls;
  logic [CW-1:0]         cnt_ofmap_chnl;
  logic [DATA_WIDTH-1:0] psum_in;
  logic                  disable_acc;
  logic                  relu_en;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  out_valid;
  logic                  cfg_err;
  logic                  busy;

  modport master (
    output data_in, en_ld_knl, en_ld_ifmap, mac_start, num_knls, cnt_ofmap_chnl,
           psum_in, disable_acc, relu_en,
    input  data_out, out_valid, cfg_err, busy
  );

  modport slave (
    input  data_in, en_ld_knl, en_ld_ifmap, mac_start, num_knls, cnt_ofmap_chnl,
           psum_in, disable_acc, relu_en,
    output data_out, out_valid, cfg_err, busy
  );
endinterface

// File: rtl/pe_round_sum.sv
// Rounds each full-precision product half-up to FRAC_BITS and sums all taps.
module pe_round_sum import pe_pkg::*; #(
  parameter int KS         = 25,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FRAC_BITS  = DEF_FRAC_BITS,
  localparam int PW = 2 * DATA_WIDTH,
  localparam int AW = DATA_WIDTH + $clog2(KS) + 1
) (
  input  logic [KS-1:0][PW-1:0] prod,
  output logic signed [AW-1:0]  sum
);
  localparam logic signed [PW-1:0] RC = PW'(rnd_const(FRAC_BITS));

  logic signed [PW-1:0] chain [KS+1];

  assign chain[0] = '0;

  // Wrap modulo 2^AW matches an AW-wide accumulator, so sum wide and truncate once.
  for (genvar i = 0; i < KS; i++) begin : g_tap
    assign chain[i+1] = chain[i] + (($signed(prod[i]) + RC) >>> FRAC_BITS);
  end

  assign sum = AW'(chain[KS]);
endmodule

// File: rtl/pe_array_conv.sv
// KxK convolution PE: kernel/ifmap shift stores feeding a 3-stage MAC pipeline.
module pe_array_conv import pe_pkg::*; #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FRAC_BITS  = DEF_FRAC_BITS,
  parameter int KNL_DIM    = DEF_KNL_DIM,
  parameter int KNL_MAXNUM = DEF_KNL_MAXNUM
) (
  input  logic           clk,
  input  logic           rst,
  pe_array_conv_if.slave bus
);
  localparam int KS     = KNL_DIM * KNL_DIM;
  localparam int PW     = 2 * DATA_WIDTH;
  localparam int AW     = DATA_WIDTH + $clog2(KS) + 1;
  localparam int NW     = $clog2(KNL_MAXNUM) + 1;
  localparam int NK     = KNL_MAXNUM * KS;
  localparam int IW     = $clog2(NK);
  localparam int STAGES = 3;
  localparam logic signed [AW:0] SMAX = (AW+1)'(sat_max(DATA_WIDTH));
  localparam logic signed [AW:0] SMIN = (AW+1)'(sat_min(DATA_WIDTH));

  logic [NK-1:0][DATA_WIDTH-1:0] knl;
  logic [KS-1:0][DATA_WIDTH-1:0] win;
  logic [STAGES:1]               vld_pipe;

  logic                 cfg_bad;
  int                   base;
  logic [KS-1:0][PW-1:0] prod_c, prod_q;
  logic                 bad1, dis1, relu1, bad2, dis2, relu2;
  logic signed [AW-1:0] sum_c, sum_q;
  logic signed [AW:0]   tot;
  logic [DATA_WIDTH-1:0] res;

  // Stores are deliberately unreset so loaded weights survive rst.
  always_ff @(posedge clk) begin
    if (bus.en_ld_knl)   knl <= {bus.data_in, knl[NK-1:1]};
    if (bus.en_ld_ifmap) win <= {bus.data_in, win[KS-1:1]};
  end

  assign cfg_bad = (bus.num_knls == '0) || (bus.num_knls > NW'(KNL_MAXNUM)) ||
                   (NW'(bus.cnt_ofmap_chnl) >= bus.num_knls);
  assign base    = (KNL_MAXNUM - int'(bus.num_knls) + int'(bus.cnt_ofmap_chnl)) * KS;

  // Window is streamed column-major, hence the transposed ifmap index.
  for (genvar r = 0; r < KNL_DIM; r++) begin : g_row
    for (genvar c = 0; c < KNL_DIM; c++) begin : g_col
      localparam int P = r * KNL_DIM + c;
      logic [IW-1:0] idx;
      assign idx       = IW'(base + P);
      assign prod_c[P] = cfg_bad ? '0 :
                         PW'($signed(knl[idx])) * PW'($signed(win[c*KNL_DIM+r]));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld_pipe <= '0;
    else     vld_pipe <= {vld_pipe[STAGES-1:1], bus.mac_start};
  end

  always_ff @(posedge clk) begin
    prod_q <= prod_c;
    bad1   <= cfg_bad;
    dis1   <= bus.disable_acc;
    relu1  <= bus.relu_en;
    sum_q  <= sum_c;
    bad2   <= bad1;
    dis2   <= dis1;
    relu2  <= relu1;
  end

  pe_round_sum #(.KS(KS), .DATA_WIDTH(DATA_WIDTH), .FRAC_BITS(FRAC_BITS)) u_round_sum (
    .prod (prod_q),
    .sum  (sum_c)
  );

  always_comb begin
    tot = (AW+1)'(sum_q) + (dis2 ? '0 : (AW+1)'($signed(bus.psum_in)));
    if (tot > SMAX)      res = DATA_WIDTH'(SMAX);
    else if (tot < SMIN) res = DATA_WIDTH'(SMIN);
    else                 res = DATA_WIDTH'(tot);
    if ((relu2 && res[DATA_WIDTH-1]) || bad2) res = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.data_out <= '0;
      bus.cfg_err  <= 1'b0;
    end else if (vld_pipe[2]) begin
      bus.data_out <= res;
      bus.cfg_err  <= bad2;
    end
  end

  assign bus.out_valid = vld_pipe[STAGES];
  assign bus.busy      = |vld_pipe;
endmodule

// File: tb/tb_pe_array_conv.sv
// Directed bench for pe_array_conv with an expected-result queue drained by an output monitor.
module tb_pe_array_conv;
  typedef struct {
    logic [31:0] data;
    logic        err;
    int          cyc;
    string       tag;
  } exp_t;

  logic clk, rst;
  int   passed = 0, total = 0, cyc = 0;
  int   knl_sh [400];
  int   win_sh [25];
  exp_t sb [$];
  exp_t e;

  pe_array_conv_if bus ();

  pe_array_conv dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  always @(negedge clk) begin
    if (bus.out_valid === 1'b1) begin
      if (sb.size() == 0) chk("unexpected_out_valid", 32'(bus.out_valid), 32'd0);
      else begin
        e = sb.pop_front();
        chk({e.tag, "_data"}, bus.data_out, e.data);
        chk({e.tag, "_err"}, 32'(bus.cfg_err), 32'(e.err));
        chk({e.tag, "_lat"}, 32'(cyc - e.cyc), 32'd3);
      end
    end
  end

  task automatic ld_knl(input int w);
    bus.data_in = 32'(w); bus.en_ld_knl = 1'b1;
    @(posedge clk); #1; bus.en_ld_knl = 1'b0;
    for (int i = 0; i < 399; i++) knl_sh[i] = knl_sh[i+1];
    knl_sh[399] = w;
  endtask

  task automatic ld_win(input int w);
    bus.data_in = 32'(w); bus.en_ld_ifmap = 1'b1;
    @(posedge clk); #1; bus.en_ld_ifmap = 1'b0;
    for (int i = 0; i < 24; i++) win_sh[i] = win_sh[i+1];
    win_sh[24] = w;
  endtask

  function automatic logic [32:0] model(int num, int cnt, bit dis, int psum, bit relu);
    longint s, p;
    int     base;
    if (num == 0 || num > 16 || cnt >= num) return {1'b1, 32'h0};
    base = (16 - num + cnt) * 25;
    s = 0;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) begin
        p = longint'(knl_sh[base + r*5 + c]) * longint'(win_sh[c*5 + r]);
        s += (p + 64'sd32768) >>> 16;
      end
    if (!dis) s += longint'(psum);
    if (s > 64'sd2147483647) s = 64'sd2147483647;
    else if (s < -64'sd2147483648) s = -64'sd2147483648;
    if (relu && s < 0) s = 0;
    return {1'b0, 32'(s)};
  endfunction

  task automatic mac(input int num, input int cnt, input bit dis, input logic [31:0] psum,
                     input bit relu, input logic [31:0] exp_d, input bit exp_e, input string tag);
    bus.num_knls = 5'(num); bus.cnt_ofmap_chnl = 4'(cnt);
    bus.disable_acc = dis; bus.psum_in = psum; bus.relu_en = relu;
    bus.mac_start = 1'b1;
    sb.push_back('{exp_d, exp_e, cyc, tag});
    @(posedge clk); #1; bus.mac_start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk({tag, "_drained"}, 32'(sb.size()), 32'd0);
  endtask

  task automatic mac_m(input int num, input int cnt, input bit dis, input int psum,
                       input bit relu, input string tag);
    logic [32:0] m;
    m = model(num, cnt, dis, psum, relu);
    mac(num, cnt, dis, 32'(psum), relu, m[31:0], m[32], tag);
  endtask

  task automatic fill_win(input int w);
    for (int i = 0; i < 25; i++) ld_win(w);
  endtask

  task automatic fill_knl(input int w);
    for (int i = 0; i < 400; i++) ld_knl(w);
  endtask

  initial begin
    logic [32:0] m;
    rst = 1'b1;
    bus.data_in = '0; bus.en_ld_knl = 1'b0; bus.en_ld_ifmap = 1'b0; bus.mac_start = 1'b0;
    bus.num_knls = '0; bus.cnt_ofmap_chnl = '0; bus.psum_in = '0;
    bus.disable_acc = 1'b0; bus.relu_en = 1'b0;
    for (int i = 0; i < 400; i++) knl_sh[i] = 0;
    for (int i = 0; i < 25; i++) win_sh[i] = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_data_out", bus.data_out, 32'h0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_cfg_err", 32'(bus.cfg_err), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    rst = 1'b0;

    fill_knl(32'h00010000);
    fill_win(32'h00020000);
    mac(16, 3, 1'b1, 32'h0, 1'b0, 32'h00320000, 1'b0, "basic");
    mac(16, 3, 1'b0, 32'h7FFF0000, 1'b0, 32'h7FFFFFFF, 1'b0, "sat_pos");

    fill_win(32'hFFFF0000);
    mac(16, 3, 1'b1, 32'h0, 1'b1, 32'h00000000, 1'b0, "relu_on");
    mac(16, 3, 1'b1, 32'h0, 1'b0, 32'hFFE70000, 1'b0, "relu_off");
    mac(16, 3, 1'b0, 32'h80000000, 1'b0, 32'h80000000, 1'b0, "sat_neg");
    mac(16, 15, 1'b1, 32'h0, 1'b0, 32'hFFE70000, 1'b0, "last_chnl");
    mac(4, 4, 1'b0, 32'h80000000, 1'b0, 32'h0, 1'b1, "bad_chnl");
    mac(0, 0, 1'b0, 32'h00010000, 1'b0, 32'h0, 1'b1, "bad_zero");
    mac(17, 0, 1'b0, 32'h00010000, 1'b0, 32'h0, 1'b1, "bad_over");

    fill_knl(32'h00000001);
    for (int i = 0; i < 24; i++) ld_win(0);
    ld_win(32'h00008000);
    mac(16, 0, 1'b1, 32'h0, 1'b0, 32'h00000001, 1'b0, "half_up_single");
    fill_win(32'h00008000);
    mac(16, 0, 1'b1, 32'h0, 1'b0, 32'h00000019, 1'b0, "half_up_all");
    fill_win(32'h00007FFF);
    mac(16, 0, 1'b1, 32'h0, 1'b0, 32'h00000000, 1'b0, "below_half");
    fill_win(32'hFFFF8000);
    mac(16, 0, 1'b1, 32'h0, 1'b0, 32'h00000000, 1'b0, "neg_half");
    fill_win(32'hFFFF7FFF);
    mac(16, 0, 1'b1, 32'h0, 1'b0, 32'hFFFFFFE7, 1'b0, "neg_below_half");

    for (int i = 0; i < 400; i++) ld_knl(((i / 25) + 1) << 16);
    fill_win(32'h00010000);
    mac(16, 3, 1'b1, 32'h0, 1'b0, 32'h00640000, 1'b0, "chnl_16_3");
    mac(4, 1, 1'b1, 32'h0, 1'b0, 32'h015E0000, 1'b0, "chnl_4_1");
    mac(16, 0, 1'b1, 32'h0, 1'b0, 32'h00190000, 1'b0, "chnl_16_0");
    mac(1, 0, 1'b1, 32'h0, 1'b0, 32'h01900000, 1'b0, "chnl_1_0");

    for (int i = 0; i < 400; i++) ld_knl(int'($urandom_range(0, 524288)) - 262144);
    for (int i = 0; i < 25; i++) ld_win(int'($urandom_range(0, 524288)) - 262144);
    mac_m(16, int'($urandom_range(0, 15)), 1'b1, 0, 1'b0, "rnd_a");
    mac_m(16, int'($urandom_range(0, 15)), 1'b0, int'($urandom_range(0, 65535)) - 32768, 1'b1, "rnd_b");
    mac_m(9, 8, 1'b0, 12345, 1'b0, "rnd_c");

    bus.num_knls = 5'd16; bus.disable_acc = 1'b1; bus.relu_en = 1'b0; bus.mac_start = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.cnt_ofmap_chnl = 4'(k);
      m = model(16, k, 1'b1, 0, 1'b0);
      sb.push_back('{m[31:0], m[32], cyc, $sformatf("b2b%0d", k)});
      @(posedge clk); #1;
    end
    bus.mac_start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("b2b_drained", 32'(sb.size()), 32'd0);

    bus.cnt_ofmap_chnl = 4'd5; bus.mac_start = 1'b1;
    m = model(16, 5, 1'b1, 0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      sb.push_back('{m[31:0], m[32], cyc, $sformatf("rstb2b%0d", k)});
      @(posedge clk); #1;
    end
    bus.mac_start = 1'b0;
    @(negedge clk); #1;
    chk("busy_before_rst", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_busy_now", 32'(bus.busy), 32'd0);
    chk("rst_valid_now", 32'(bus.out_valid), 32'd0);
    chk("rst_dout_now", bus.data_out, 32'h0);
    chk("rst_results_seen", 32'(sb.size()), 32'd2);
    sb.delete();
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("post_rst_no_valid", 32'(bus.out_valid), 32'd0);
    end
    mac_m(16, 5, 1'b1, 0, 1'b0, "store_survives_rst");

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/pe_array_conv.md
PE_ARRAY_CONV -- requirements
Module: pe_array_conv

Interface
REQ-001 Parameter DATA_WIDTH, 32, width of the signed fixed-point word.
REQ-002 Parameter FRAC_BITS, 16, number of fractional bits in every word.
REQ-003 Parameter KNL_DIM, 5, kernel edge length K; kernel size is KS = K*K words.
REQ-004 Parameter KNL_MAXNUM, 16, maximum number of kernels held.
REQ-005 Port clk, input, 1, single clock; all state updates on its rising edge.
REQ-006 Port rst, input, 1, reset, asynchronous and active-high.
REQ-007 Port data_in, input, DATA_WIDTH, load word for kernels or ifmap.
REQ-008 Port en_ld_knl, input, 1, shifts data_in into the kernel store this cycle.
REQ-009 Port en_ld_ifmap, input, 1, shifts data_in into the ifmap window this cycle.
REQ-010 Port mac_start, input, 1, launches one KS-tap MAC using the current window.
REQ-011 Port num_knls, input, clog2(KNL_MAXNUM)+1, number of valid kernels loaded.
REQ-012 Port cnt_ofmap_chnl, input, clog2(KNL_MAXNUM), output channel to use.
REQ-013 Port psum_in, input, DATA_WIDTH, partial sum added at the output stage.
REQ-014 Port disable_acc, input, 1, ignore psum_in for this MAC (first input channel).
REQ-015 Port relu_en, input, 1, clamp negative results to 0.
REQ-016 Port data_out, output, DATA_WIDTH, result word.
REQ-017 Port out_valid, output, 1, data_out is valid this cycle.
REQ-018 Port cfg_err, output, 1, the result in flight was produced with an illegal channel config.
REQ-019 Port busy, output, 1, at least one MAC is in the pipeline.

Function
REQ-020 Kernel store: KNL_MAXNUM*KS words; on en_ld_knl, word[i] <= word[i+1] and the top word <= data_in; no reset.
REQ-021 Ifmap window: KS words, same shift rule on en_ld_ifmap; loads take effect on the same edge as a coincident mac_start, so the MAC uses pre-edge contents.
REQ-022 Kernel base = (KNL_MAXNUM - num_knls + cnt_ofmap_chnl)*KS, computed in full width without wrap.
REQ-023 Tap pairing: product p = r*K + c uses kernel[base + r*K + c] times ifmap[c*K + r] (ifmap streamed column-major).
REQ-024 Config is illegal when num_knls == 0, num_knls > KNL_MAXNUM, or cnt_ofmap_chnl >= num_knls; an illegal MAC forces the sum to 0 and asserts cfg_err with its out_valid.
REQ-025 Stage 1 (edge after mac_start): KS full 2*DATA_WIDTH products are registered; config, disable_acc and relu_en are captured with them.
REQ-026 Stage 2: each product is rounded half-up to FRAC_BITS (add 2^(FRAC_BITS-1), arithmetic shift right by FRAC_BITS); the KS terms are summed in a DATA_WIDTH+clog2(KS)+1 bit accumulator and registered.
REQ-027 Stage 3: add psum_in sampled this cycle (0 if disable_acc), saturate to the signed DATA_WIDTH range, apply relu if enabled, and register to data_out.
REQ-028 Latency: mac_start at edge t gives out_valid high for exactly one cycle after edge t+3; back-to-back mac_start every cycle is allowed and gives one result per cycle.
REQ-029 data_out holds its last value while out_valid is low.
REQ-030 busy = OR of the three stage-valid bits.

Reset
REQ-031 When rst is asserted: data_out=0, out_valid=0, cfg_err=0, busy=0, and all stage-valid bits clear immediately.
REQ-032 A MAC in flight at reset is discarded; no out_valid appears for it after rst deasserts.
REQ-033 The kernel and ifmap stores are not reset; their contents survive rst.

Structure
REQ-034 Package pe_pkg holds the default widths, FRAC_BITS, the rounding constant and the saturation min/max functions.
REQ-035 The rounded adder tree (stage 2) is a sub-module named pe_round_sum, parameterised by KS, DATA_WIDTH and FRAC_BITS.

Verification
REQ-036 Load 16 kernels each of all 0x00010000 and a window of all 0x00020000; num_knls=16, chnl=3, disable_acc=1 -> data_out=0x00320000 at t+3.
REQ-037 Same setup with disable_acc=0 and psum_in=0x7FFF0000 -> data_out=0x7FFFFFFF (saturated).
REQ-038 Window all 0xFFFF0000 (-1.0) with relu_en=1 -> data_out=0; with relu_en=0 -> data_out=0xFFE70000.
REQ-039 num_knls=4, cnt_ofmap_chnl=4 -> out_valid with cfg_err=1 and data_out=0.
REQ-040 mac_start held high for 4 cycles -> 4 consecutive out_valid pulses; assert rst after the 2nd result -> no further out_valid, and busy=0 in the same cycle.
REQ-041 Single tap 0x00000001 x 0x00008000 -> product rounds up to 1 (half-up), not down to 0.
